// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS core: decodes the IR opcode, sequences the
// shared datapath one instruction at a time, traps on unknown opcodes and counts retirements.
module multicycle_control (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        branch,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q;
    state_t state_d;
    logic   retire;

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= 32'd0;
        end else if (retire) begin
            retired <= retired + 32'd1;
        end
    end

    // Memory handshake: mem_read/mem_write (with iord) are held every cycle of FETCH,
    // MEMRD or MEMWR until mem_ready is seen high; the transfer completes on that edge.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    // Outputs are held at zero for as long as rst_n is low, so nothing leaks out during reset.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b01;
                    pc_src    = 2'b01;
                    branch    = 1'b1;
                end
                S_ADDIWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: a per-instruction cycle model builds the expected
// state/control trace, and each cycle of the DUT is compared against it.
module tb_multicycle_control;

    logic        clk;
    logic        rst_n;
    logic [5:0]  op;
    logic        mem_ready;
    logic        pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
    logic [1:0]  alu_src_b, alu_op, pc_src;
    logic [3:0]  state;
    logic [31:0] retired;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .branch(branch), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .illegal(illegal), .state(state), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
        logic       ret;
    } step_t;

    step_t       exp_q[$];
    logic [5:0]  op_tab[6];
    logic [31:0] exp_ret;
    logic [31:0] watch_target;
    logic [16:0] ctrl_obs;
    int          total, bad;
    int          cyc, watch_cyc, obs_mw, obs_rdio;

    assign ctrl_obs = {pc_write, branch, iord, mem_read, mem_write, ir_write, mem_to_reg,
                       reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, illegal};

    // Control word each state must present, straight from the state/output table.
    function automatic logic [16:0] exp_ctrl(input int st, input logic mr);
        logic pw, br, io, rd_, wr_, irw, m2r, rdst, rw, sa, il;
        logic [1:0] sb, ao, ps;
        {pw, br, io, rd_, wr_, irw, m2r, rdst, rw, sa, il} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            0:  begin rd_ = 1; sb = 2'b01; irw = mr; pw = mr; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin io = 1; rd_ = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; wr_ = 1; end
            6:  begin sa = 1; ao = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin sa = 1; ao = 2'b01; ps = 2'b01; br = 1; end
            9:  begin sa = 1; sb = 2'b10; end
            10: rw = 1;
            11: begin ps = 2'b10; pw = 1; end
            12: il = 1;
            default: ;
        endcase
        return {pw, br, io, rd_, wr_, irw, m2r, rdst, rw, sa, sb, ao, ps, il};
    endfunction

    task automatic push_step(input int st, input logic mr, input logic [5:0] o, input logic ret);
        step_t s;
        s.st = 4'(st); s.mr = mr; s.op = o; s.ret = ret;
        exp_q.push_back(s);
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    // Expected cycle trace of one instruction; op is only meaningful in DECODE and MEMADR.
    task automatic add_instr(input int kind, input int fstall, input int mstall);
        logic [5:0] o;
        o = op_tab[kind];
        for (int i = 0; i < fstall; i++) push_step(0, 1'b0, rnd_op(), 1'b0);
        push_step(0, 1'b1, rnd_op(), 1'b0);
        push_step(1, rnd_bit(), o, 1'b0);
        case (kind)
            K_LW: begin
                push_step(2, rnd_bit(), o, 1'b0);
                for (int i = 0; i < mstall; i++) push_step(3, 1'b0, rnd_op(), 1'b0);
                push_step(3, 1'b1, rnd_op(), 1'b0);
                push_step(4, rnd_bit(), rnd_op(), 1'b1);
            end
            K_SW: begin
                push_step(2, rnd_bit(), o, 1'b0);
                for (int i = 0; i < mstall; i++) push_step(5, 1'b0, rnd_op(), 1'b0);
                push_step(5, 1'b1, rnd_op(), 1'b1);
            end
            K_R: begin
                push_step(6, rnd_bit(), rnd_op(), 1'b0);
                push_step(7, rnd_bit(), rnd_op(), 1'b1);
            end
            K_BEQ:  push_step(8, rnd_bit(), rnd_op(), 1'b1);
            K_ADDI: begin
                push_step(9, rnd_bit(), rnd_op(), 1'b0);
                push_step(10, rnd_bit(), rnd_op(), 1'b1);
            end
            default: push_step(11, rnd_bit(), rnd_op(), 1'b1);
        endcase
    endtask

    // Entered just after a rising edge; drives one queued step per cycle and checks mid-cycle.
    task automatic run_queue();
        step_t s;
        while (exp_q.size() > 0) begin
            s = exp_q.pop_front();
            op = s.op;
            mem_ready = s.mr;
            @(negedge clk);
            total++;
            if (state !== s.st) begin
                bad++;
                $display("FAIL state: got %0d want %0d", state, s.st);
            end
            total++;
            if (ctrl_obs !== exp_ctrl(int'(s.st), s.mr)) begin
                bad++;
                $display("FAIL ctrl st=%0d: got %b want %b", s.st, ctrl_obs, exp_ctrl(int'(s.st), s.mr));
            end
            total++;
            if (retired !== exp_ret) begin
                bad++;
                $display("FAIL retired: got %0h want %0h", retired, exp_ret);
            end
            if (mem_write === 1'b1) obs_mw++;
            if (mem_read === 1'b1 && iord === 1'b1) obs_rdio++;
            @(posedge clk);
            #1;
            if (s.ret) exp_ret++;
            cyc++;
            if (watch_cyc < 0 && retired === watch_target) watch_cyc = cyc;
        end
    endtask

    task automatic start_watch(input int n);
        cyc = 0; watch_cyc = -1; obs_mw = 0; obs_rdio = 0;
        watch_target = exp_ret + 32'(n);
    endtask

    task automatic release_reset();
        mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (mem_read !== 1'b1 || state !== 4'd0) begin
            bad++;
            $display("FAIL first_fetch: mem_read=%b state=%0d want 1/0", mem_read, state);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        mem_ready = 1'b1;
        #1;
        total++;
        if (state !== 4'd0 || retired !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: state=%0d retired=%0h want 0/0", state, retired);
        end
        total++;
        if (ctrl_obs !== 17'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0", ctrl_obs);
        end
        exp_ret = 32'd0;
        release_reset();
    endtask

    task automatic test_rtype();
        start_watch(1);
        add_instr(K_R, 0, 0);
        run_queue();
        total++;
        if (watch_cyc !== 4 || retired !== 32'd1) begin
            bad++;
            $display("FAIL rtype_cpi: cycles=%0d retired=%0d want 4/1", watch_cyc, retired);
        end
    endtask

    task automatic test_lw_stall();
        start_watch(1);
        add_instr(K_LW, 0, 3);
        run_queue();
        total++;
        if (watch_cyc !== 8) begin
            bad++;
            $display("FAIL lw_cycles: got %0d want 8", watch_cyc);
        end
        total++;
        if (obs_rdio !== 4) begin
            bad++;
            $display("FAIL lw_rd_iord: got %0d want 4", obs_rdio);
        end
    endtask

    task automatic test_back_to_back();
        start_watch(3);
        add_instr(K_SW, 0, 0);
        add_instr(K_BEQ, 0, 0);
        add_instr(K_J, 0, 0);
        run_queue();
        total++;
        if (watch_cyc !== 10) begin
            bad++;
            $display("FAIL b2b_cycles: got %0d want 10", watch_cyc);
        end
        total++;
        if (obs_mw !== 1) begin
            bad++;
            $display("FAIL b2b_mem_write: pulses=%0d want 1", obs_mw);
        end
    endtask

    task automatic test_trap();
        push_step(0, 1'b1, rnd_op(), 1'b0);
        push_step(1, 1'b1, 6'b111111, 1'b0);
        for (int i = 0; i < 20; i++) push_step(12, rnd_bit(), rnd_op(), 1'b0);
        run_queue();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (illegal !== 1'b0 || state !== 4'd0 || retired !== 32'd0) begin
            bad++;
            $display("FAIL trap_reset: illegal=%b state=%0d retired=%0h want 0/0/0", illegal, state, retired);
        end
        exp_ret = 32'd0;
        release_reset();
    endtask

    task automatic test_async_reset();
        add_instr(K_ADDI, 1, 0);
        push_step(0, 1'b1, rnd_op(), 1'b0);
        push_step(1, 1'b1, op_tab[K_LW], 1'b0);
        push_step(2, 1'b1, op_tab[K_LW], 1'b0);
        push_step(3, 1'b0, rnd_op(), 1'b0);
        run_queue();
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 4'd0 || ctrl_obs !== 17'd0 || retired !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: state=%0d ctrl=%b retired=%0h want 0/0/0", state, ctrl_obs, retired);
        end
        exp_ret = 32'd0;
        release_reset();
    endtask

    task automatic test_wrap();
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        exp_ret = 32'hFFFF_FFFF;
        add_instr(K_ADDI, 0, 0);
        run_queue();
        total++;
        if (retired !== 32'd0) begin
            bad++;
            $display("FAIL wrap: got %0h want 0", retired);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            add_instr($urandom_range(0, 5), $urandom_range(0, 3), $urandom_range(0, 3));
        run_queue();
    endtask

    initial begin
        op_tab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        total = 0; bad = 0;
        rst_n = 1'b0;
        op = 6'd0;
        mem_ready = 1'b0;
        exp_ret = 32'd0;
        test_reset();
        test_rtype();
        test_lw_stall();
        test_back_to_back();
        test_trap();
        test_async_reset();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
